// File: rtl/tone_contour_gen.sv
// Pitch-contour tone generator.
// A 3-bit contour code (silence / flat / rising / falling) drives a phase
// accumulator. The accumulator produces an unsigned sawtooth over four equal
// segments. The tuning word steps by +/-25% at each segment boundary using
// shift-add arithmetic.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a code; tone_ready_out high; sample_out at midscale
// PLAY  | generating samples; divider, sample and segment counters run
// DONE  | single cycle; pulses done_out, returns output to midscale
module tone_contour_gen #(
   parameter int          SAMPLE_DIV      = 2268,
   parameter int          SEGMENT_SAMPLES = 4410,
   parameter logic [31:0] BASE_TW         = 32'd21426137
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [2:0] tone_in,
   input  logic       tone_valid_in,
   output logic       tone_ready_out,
   input  logic       abort_in,
   output logic [7:0] sample_out,
   output logic       sample_valid_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       error_out
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int SMP_W = (SEGMENT_SAMPLES > 1) ? $clog2(SEGMENT_SAMPLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SEGMENT_SAMPLES - 1);

   localparam logic [2:0] CODE_SILENCE = 3'b000;
   localparam logic [2:0] CODE_FLAT    = 3'b001;
   localparam logic [2:0] CODE_RISE    = 3'b010;
   localparam logic [2:0] CODE_FALL    = 3'b100;
   localparam logic [7:0] MIDSCALE     = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [2:0]       code_q, code_n;
   logic [31:0]      tw_q, tw_n;
   logic [31:0]      phase_q, phase_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic [SMP_W-1:0] smp_q, smp_n;
   logic [1:0]       seg_q, seg_n;
   logic [7:0]       sample_q, sample_n;
   logic             sval_q, sval_n;
   logic             busy_q, busy_n;
   logic             done_q, done_n;
   logic             err_q, err_n;
   logic             ready_q, ready_n;

   logic             code_ok;
   logic [31:0]      phase_sum;
   logic [32:0]      tw_up;
   logic [31:0]      tw_dn;
   logic [31:0]      tw_rise;
   logic [31:0]      tw_fall;

   assign code_ok   = (tone_in == CODE_SILENCE) || (tone_in == CODE_FLAT) ||
                      (tone_in == CODE_RISE)    || (tone_in == CODE_FALL);
   assign phase_sum = phase_q + tw_q;

   // +25%: 33-bit sum so a carry out can be saturated rather than wrapped.
   assign tw_up   = {1'b0, tw_q} + {3'b000, tw_q[31:2]};
   assign tw_rise = tw_up[32] ? 32'hFFFF_FFFF : tw_up[31:0];
   // -25%: floored at 1 so a falling contour never stalls the accumulator.
   assign tw_dn   = tw_q - {2'b00, tw_q[31:2]};
   assign tw_fall = (tw_dn == 32'd0) ? 32'd1 : tw_dn;

   // Next-state and next-output decode for the contour sequencer.
   always_comb begin
      state_n  = state_q;
      code_n   = code_q;
      tw_n     = tw_q;
      phase_n  = phase_q;
      div_n    = div_q;
      smp_n    = smp_q;
      seg_n    = seg_q;
      sample_n = sample_q;
      sval_n   = 1'b0;
      done_n   = 1'b0;
      err_n    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tone_valid_in && ready_q) begin
               if (code_ok) begin
                  state_n = ST_PLAY;
                  code_n  = tone_in;
                  tw_n    = BASE_TW;
                  phase_n = 32'd0;
                  div_n   = '0;
                  smp_n   = '0;
                  seg_n   = 2'd0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         ST_PLAY: begin
            if (abort_in) begin
               // Abort takes priority over a coincident divider wrap.
               state_n  = ST_IDLE;
               sample_n = MIDSCALE;
            end else if (div_q == DIV_LAST) begin
               div_n    = '0;
               phase_n  = phase_sum;
               sample_n = (code_q == CODE_SILENCE) ? MIDSCALE : phase_sum[31:24];
               sval_n   = 1'b1;
               if (smp_q == SMP_LAST) begin
                  smp_n = '0;
                  if (seg_q == 2'd3) begin
                     state_n = ST_DONE;
                  end else begin
                     seg_n = seg_q + 2'd1;
                     case (code_q)
                        CODE_RISE: tw_n = tw_rise;
                        CODE_FALL: tw_n = tw_fall;
                        default:   tw_n = tw_q;
                     endcase
                  end
               end else begin
                  smp_n = smp_q + SMP_W'(1);
               end
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end

         ST_DONE: begin
            done_n   = 1'b1;
            sample_n = MIDSCALE;
            state_n  = ST_IDLE;
         end

         default: begin
            state_n  = ST_IDLE;
            sample_n = MIDSCALE;
         end
      endcase

      // Ready only after a full cycle spent in IDLE, so a code can never be
      // taken on the edge that leaves DONE or PLAY.
      ready_n = (state_q == ST_IDLE) && (state_n == ST_IDLE);
      busy_n  = (state_n == ST_PLAY);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_IDLE;
         code_q   <= 3'b000;
         tw_q     <= 32'd0;
         phase_q  <= 32'd0;
         div_q    <= '0;
         smp_q    <= '0;
         seg_q    <= 2'd0;
         sample_q <= MIDSCALE;
         sval_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_n;
         code_q   <= code_n;
         tw_q     <= tw_n;
         phase_q  <= phase_n;
         div_q    <= div_n;
         smp_q    <= smp_n;
         seg_q    <= seg_n;
         sample_q <= sample_n;
         sval_q   <= sval_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         err_q    <= err_n;
         ready_q  <= ready_n;
      end
   end

   assign tone_ready_out   = ready_q;
   assign sample_out       = sample_q;
   assign sample_valid_out = sval_q;
   assign busy_out         = busy_q;
   assign done_out         = done_q;
   assign error_out        = err_q;

endmodule

// File: tb/tb_tone_contour_gen.sv
// Bench for tone_contour_gen with small parameters.
// Expected samples come from an arithmetic model of the contour, using the
// per-segment tuning word and a running phase sum.
module tb_tone_contour_gen;

   localparam int          SD = 4;
   localparam int          SS = 8;
   localparam int          NS = 4 * SS;
   localparam logic [31:0] BT = 32'h0100_0000;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic [2:0] tone_in = 3'b000;
   logic       tone_valid_in = 1'b0;
   logic       tone_ready_out;
   logic       abort_in = 1'b0;
   logic [7:0] sample_out;
   logic       sample_valid_out;
   logic       busy_out;
   logic       done_out;
   logic       error_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_s [NS];
   logic [7:0] got_s [NS];
   int         nstr;

   tone_contour_gen #(
      .SAMPLE_DIV      (SD),
      .SEGMENT_SAMPLES (SS),
      .BASE_TW         (BT)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .tone_in          (tone_in),
      .tone_valid_in    (tone_valid_in),
      .tone_ready_out   (tone_ready_out),
      .abort_in         (abort_in),
      .sample_out       (sample_out),
      .sample_valid_out (sample_valid_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
      .error_out        (error_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Tuning word in force during a segment: 1.25x or 0.75x per step.
   function automatic logic [31:0] seg_tw(input logic [2:0] code, input int seg);
      longint t = longint'(BT);
      for (int s = 1; s <= seg; s++) begin
         if (code == 3'b010) begin
            t = t + t / 4;
            if (t > 64'h0000_0000_FFFF_FFFF) t = 64'h0000_0000_FFFF_FFFF;
         end else if (code == 3'b100) begin
            t = t - t / 4;
            if (t < 1) t = 1;
         end
      end
      return t[31:0];
   endfunction

   task automatic build_model(input logic [2:0] code);
      logic [31:0] ph = 32'd0;
      for (int i = 0; i < NS; i++) begin
         ph = ph + seg_tw(code, i / SS);
         exp_s[i] = (code == 3'b000) ? 8'h80 : ph[31:24];
      end
   endtask

   // Accept a code, then follow the contour cycle by cycle. abort_at is
   // the edge index after acceptance at which abort_in is seen (0 = none).
   task automatic run_play(input logic [2:0] code, input int abort_at, input bit bp);
      int  last;
      logic exp_sv;
      build_model(code);
      @(negedge clk_in);
      chk("ready_pre", 32'(tone_ready_out), 32'd1);
      tone_in = code;
      tone_valid_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      tone_valid_in = 1'b0;
      chk("ready_acc", 32'(tone_ready_out), 32'd0);
      chk("busy_acc", 32'(busy_out), 32'd1);
      last = (abort_at != 0) ? abort_at + 2 : 131;
      nstr = 0;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk_in);
         exp_sv = (k % SD == 0) && (k <= SD * NS) && (abort_at == 0 || k < abort_at);
         chk("strobe", 32'(sample_valid_out), 32'(exp_sv));
         if (sample_valid_out && nstr < NS) begin
            chk("sample", 32'(sample_out), 32'(exp_s[nstr]));
            got_s[nstr] = sample_out;
            nstr++;
         end
         chk("done", 32'(done_out), 32'(abort_at == 0 && k == SD * NS + 1));
         chk("busy", 32'(busy_out), 32'((abort_at != 0) ? (k < abort_at) : (k < SD * NS)));
         chk("ready", 32'(tone_ready_out),
             32'((abort_at != 0) ? (k >= abort_at + 1) : (k >= SD * NS + 2)));
         chk("err", 32'(error_out), 32'd0);
         if (k == ((abort_at != 0) ? abort_at : SD * NS + 1))
            chk("idle_sample", 32'(sample_out), 32'h80);
         abort_in = (abort_at != 0) && (k + 1 == abort_at);
         if (bp && (k + 1 < ((abort_at != 0) ? abort_at : 120)) && ($urandom_range(0, 3) == 0)) begin
            tone_valid_in = 1'b1;
            tone_in = 3'b010;
         end else begin
            tone_valid_in = 1'b0;
         end
      end
      abort_in = 1'b0;
      tone_valid_in = 1'b0;
      if (abort_at == 0) chk("nstrobes", 32'(nstr), 32'(NS));
   endtask

   task automatic run_invalid(input logic [2:0] code);
      @(negedge clk_in);
      tone_in = code;
      tone_valid_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      tone_valid_in = 1'b0;
      chk("err_pulse", 32'(error_out), 32'd1);
      chk("err_ready", 32'(tone_ready_out), 32'd1);
      chk("err_busy", 32'(busy_out), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_in);
         chk("err_clr", 32'(error_out), 32'd0);
         chk("err_strobe", 32'(sample_valid_out), 32'd0);
         chk("err_busy2", 32'(busy_out), 32'd0);
         chk("err_ready2", 32'(tone_ready_out), 32'd1);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(tone_ready_out), 32'd1);
      chk({tag, "_sample"}, 32'(sample_out), 32'h80);
      chk({tag, "_sval"}, 32'(sample_valid_out), 32'd0);
      chk({tag, "_busy"}, 32'(busy_out), 32'd0);
      chk({tag, "_done"}, 32'(done_out), 32'd0);
      chk({tag, "_err"}, 32'(error_out), 32'd0);
   endtask

   initial begin
      logic [2:0] rc;
      int         ab;
      #12;
      chk_reset_vals("rst0");
      @(negedge clk_in);
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);

      run_play(3'b001, 0, 1'b0);
      chk("flat_first", 32'(got_s[0]), 32'h01);
      chk("flat_last", 32'(got_s[NS-1]), 32'h20);
      run_play(3'b010, 0, 1'b1);
      chk("rise_seg1", 32'(got_s[SS]), 32'h09);
      run_play(3'b100, 0, 1'b0);
      chk("fall_seg1", 32'(got_s[SS]), 32'h08);
      run_play(3'b000, 0, 1'b1);
      run_invalid(3'b011);
      run_play(3'b010, 50, 1'b1);
      run_play(3'b001, 52, 1'b0);

      @(negedge clk_in);
      abort_in = 1'b1;
      @(negedge clk_in);
      abort_in = 1'b0;
      chk("idle_abort_busy", 32'(busy_out), 32'd0);
      chk("idle_abort_ready", 32'(tone_ready_out), 32'd1);

      // Asynchronous reset in segment 2, then a fresh contour from phase 0.
      @(negedge clk_in);
      tone_in = 3'b010;
      tone_valid_in = 1'b1;
      @(negedge clk_in);
      tone_valid_in = 1'b0;
      repeat (75) @(negedge clk_in);
      chk("busy_mid", 32'(busy_out), 32'd1);
      #1 rst_in = 1'b0;
      #1 chk_reset_vals("rst_mid");
      @(negedge clk_in);
      rst_in = 1'b1;
      run_play(3'b001, 0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         case ($urandom_range(0, 3))
            0: rc = 3'b000;
            1: rc = 3'b001;
            2: rc = 3'b010;
            default: rc = 3'b100;
         endcase
         ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 127)) : 0;
         run_play(rc, ab, 1'(($urandom_range(0, 1))));
         repeat ($urandom_range(0, 3)) @(negedge clk_in);
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0: rc = 3'b011;
               1: rc = 3'b101;
               2: rc = 3'b110;
               default: rc = 3'b111;
            endcase
            run_invalid(rc);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
